// File: rtl/iobus_chk_pkg.sv
// -----------------------------------------------------------------------------
// iobus_chk_pkg
// Shared types for the OTTER I/O bus checker: checker state encoding and the
// failure classification reported on fail_code.
// -----------------------------------------------------------------------------
package iobus_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } chk_state_t;

    typedef enum logic [1:0] {
        FAIL_NONE     = 2'd0,
        FAIL_MISMATCH = 2'd1,
        FAIL_OVERRUN  = 2'd2,
        FAIL_TIMEOUT  = 2'd3
    } chk_fail_t;

endpackage

// File: rtl/iobus_chk_fifo.sv
// -----------------------------------------------------------------------------
// iobus_chk_fifo
// Synchronous FIFO holding the expected values of one checker channel.
// The head entry is presented combinationally, so a value pushed at one edge
// is visible on head from the next cycle on.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   flush      empties the FIFO (wins over push/pop in the same cycle)
//   push       write push_data (ignored when full)
//   push_data  value to enqueue
//   pop        discard the head entry (ignored when empty)
//   head       oldest stored value
//   empty      no entries stored
//   full       DEPTH entries stored
// -----------------------------------------------------------------------------
module iobus_chk_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order of statements.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count, so
    // stale contents are never observed and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/iobus_checker.sv
// -----------------------------------------------------------------------------
// iobus_checker
// Hardware self-check monitor for the OTTER SoC I/O bus. Expected values are
// queued per channel while IDLE; after start, every bus write hitting a
// channel address is compared against that channel's queue head. The result
// (PASS / FAIL / TIMEOUT) is sticky until clear or rst.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iobus_out/addr/wr observed bus write (data, address, one-cycle strobe)
//   exp_valid/ready   expected-value push handshake (IDLE only)
//   exp_ch, exp_data  target channel and value of the push
//   start             IDLE -> RUN (or straight to PASS with nothing queued)
//   clear             flush everything and return to IDLE, any state
//   done, pass        verdict reached / verdict is PASS
//   fail_code         NONE / MISMATCH / OVERRUN / TIMEOUT
//   fail_ch           channel of the first failure
//   fail_seen/exp     observed and expected data at the first failure
//   match_count       matched writes, saturating
// -----------------------------------------------------------------------------
module iobus_checker
    import iobus_chk_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          DEPTH          = 16,
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF0000,
    parameter int          ADDR_STRIDE    = 4,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter int          STOP_ON_FAIL   = 1,
    localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     iobus_out,
    input  logic [31:0]     iobus_addr,
    input  logic            iobus_wr,
    input  logic            exp_valid,
    output logic            exp_ready,
    input  logic [CH_W-1:0] exp_ch,
    input  logic [31:0]     exp_data,
    input  logic            start,
    input  logic            clear,
    output logic            done,
    output logic            pass,
    output logic [1:0]      fail_code,
    output logic [CH_W-1:0] fail_ch,
    output logic [31:0]     fail_seen,
    output logic [31:0]     fail_exp,
    output logic [15:0]     match_count
);

    // Watchdog counts 0 .. TIMEOUT_CYCLES-1; the edge that would reach the
    // limit is the one that enters TIMEOUT.
    localparam int            WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    chk_state_t      state;
    chk_fail_t       fail_q;
    logic [CH_W-1:0] fail_ch_q;
    logic [31:0]     fail_seen_q;
    logic [31:0]     fail_exp_q;
    logic [15:0]     match_q;
    logic [WD_W-1:0] wd;

    logic [NUM_CH-1:0] hit_oh;
    logic [NUM_CH-1:0] push_v;
    logic [NUM_CH-1:0] pop_v;
    logic [NUM_CH-1:0] empty_v;
    logic [NUM_CH-1:0] full_v;
    logic [31:0]       head_v [NUM_CH];

    logic            hit_any;
    logic [CH_W-1:0] hit_ch;
    logic [31:0]     sel_head;
    logic            sel_empty;
    logic            sel_full;
    logic            all_empty;
    logic            frozen;
    logic            process_hit;
    logic            push_acc;
    logic            timeout_now;

    // ---------------------------------------------------------------- channels
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [31:0] CH_ADDR = BASE_ADDR + 32'(i * ADDR_STRIDE);

        assign hit_oh[i] = iobus_wr && (iobus_addr == CH_ADDR);
        assign push_v[i] = push_acc && (exp_ch == CH_W'(i));

        iobus_chk_fifo #(
            .WIDTH (32),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (clear),
            .push      (push_v[i]),
            .push_data (exp_data),
            .pop       (pop_v[i]),
            .head      (head_v[i]),
            .empty     (empty_v[i]),
            .full      (full_v[i])
        );
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        hit_any   = 1'b0;
        hit_ch    = '0;
        sel_head  = '0;
        sel_empty = 1'b0;
        sel_full  = 1'b1;   // a channel number with no FIFO is never ready
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit_any && hit_oh[i]) begin
                hit_any   = 1'b1;
                hit_ch    = CH_W'(i);
                sel_head  = head_v[i];
                sel_empty = empty_v[i];
            end
            if (exp_ch == CH_W'(i)) sel_full = full_v[i];
        end
    end

    assign all_empty = &empty_v;
    assign frozen    = (STOP_ON_FAIL != 0) && (fail_q != FAIL_NONE);
    assign exp_ready = (state == ST_IDLE) && !sel_full;
    assign push_acc  = exp_valid && exp_ready && !clear;

    // Once every queue has drained the verdict is taken on this edge, so a
    // stray write in the same cycle is not allowed to alter the fail fields.
    assign process_hit = (state == ST_RUN) && hit_any && !all_empty && !frozen && !clear;
    assign timeout_now = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);

    always_comb begin
        pop_v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop_v[i] = process_hit && (hit_ch == CH_W'(i)) && !empty_v[i];
        end
    end

    // --------------------------------------------------- FSM, watchdog, capture
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state       <= ST_IDLE;
            fail_q      <= FAIL_NONE;
            fail_ch_q   <= '0;
            fail_seen_q <= '0;
            fail_exp_q  <= '0;
            match_q     <= '0;
            wd          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd <= '0;
                    if (start) begin
                        // A push accepted this cycle lands in a FIFO, so the
                        // run is not empty even though empty_v is still set.
                        state <= (all_empty && !push_acc) ? ST_PASS : ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (hit_any)           wd <= '0;
                    else if (!timeout_now) wd <= wd + 1'b1;

                    if (process_hit) begin
                        if (!sel_empty) begin
                            if (sel_head == iobus_out) begin
                                if (match_q != 16'hFFFF) match_q <= match_q + 16'd1;
                            end else if (fail_q == FAIL_NONE) begin
                                fail_q      <= FAIL_MISMATCH;
                                fail_ch_q   <= hit_ch;
                                fail_seen_q <= iobus_out;
                                fail_exp_q  <= sel_head;
                            end
                        end else if (fail_q == FAIL_NONE) begin
                            fail_q      <= FAIL_OVERRUN;
                            fail_ch_q   <= hit_ch;
                            fail_seen_q <= iobus_out;
                            fail_exp_q  <= '0;
                        end
                    end

                    // Verdicts use the registered fail/occupancy, so they land
                    // one edge after the write that caused them.
                    if (frozen) begin
                        state <= ST_FAIL;
                    end else if (all_empty) begin
                        state <= (fail_q != FAIL_NONE) ? ST_FAIL : ST_PASS;
                    end else if (!hit_any && timeout_now) begin
                        state <= ST_TIMEOUT;
                        if (fail_q == FAIL_NONE) fail_q <= FAIL_TIMEOUT;
                    end
                end

                ST_PASS, ST_FAIL, ST_TIMEOUT: state <= state;

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done        = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
    assign pass        = (state == ST_PASS);
    assign fail_code   = fail_q;
    assign fail_ch     = fail_ch_q;
    assign fail_seen   = fail_seen_q;
    assign fail_exp    = fail_exp_q;
    assign match_count = match_q;

endmodule

// File: tb/tb_iobus_checker.sv
// -----------------------------------------------------------------------------
// tb_iobus_checker
// Directed bench for iobus_checker. Two instances share all stimulus: one
// stops on the first failure, the other keeps running and latches it. Both
// use a 50-cycle watchdog. Inputs change 1 time unit after the rising edge
// and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_iobus_checker;

    logic        clk;
    logic        rst;
    logic [31:0] iobus_out;
    logic [31:0] iobus_addr;
    logic        iobus_wr;
    logic        exp_valid;
    logic [1:0]  exp_ch;
    logic [31:0] exp_data;
    logic        start;
    logic        clear;

    logic        a_exp_ready, a_done, a_pass;
    logic [1:0]  a_fail_code, a_fail_ch;
    logic [31:0] a_fail_seen, a_fail_exp;
    logic [15:0] a_match;

    logic        b_exp_ready, b_done, b_pass;
    logic [1:0]  b_fail_code, b_fail_ch;
    logic [31:0] b_fail_seen, b_fail_exp;
    logic [15:0] b_match;

    int checks = 0;
    int errors = 0;

    iobus_checker #(
        .NUM_CH(4), .DEPTH(16), .BASE_ADDR(32'hFFFF0000), .ADDR_STRIDE(4),
        .TIMEOUT_CYCLES(50), .STOP_ON_FAIL(1)
    ) u_dut_stop (
        .clk(clk), .rst(rst), .iobus_out(iobus_out), .iobus_addr(iobus_addr),
        .iobus_wr(iobus_wr), .exp_valid(exp_valid), .exp_ready(a_exp_ready),
        .exp_ch(exp_ch), .exp_data(exp_data), .start(start), .clear(clear),
        .done(a_done), .pass(a_pass), .fail_code(a_fail_code), .fail_ch(a_fail_ch),
        .fail_seen(a_fail_seen), .fail_exp(a_fail_exp), .match_count(a_match)
    );

    iobus_checker #(
        .NUM_CH(4), .DEPTH(16), .BASE_ADDR(32'hFFFF0000), .ADDR_STRIDE(4),
        .TIMEOUT_CYCLES(50), .STOP_ON_FAIL(0)
    ) u_dut_cont (
        .clk(clk), .rst(rst), .iobus_out(iobus_out), .iobus_addr(iobus_addr),
        .iobus_wr(iobus_wr), .exp_valid(exp_valid), .exp_ready(b_exp_ready),
        .exp_ch(exp_ch), .exp_data(exp_data), .start(start), .clear(clear),
        .done(b_done), .pass(b_pass), .fail_code(b_fail_code), .fail_ch(b_fail_ch),
        .fail_seen(b_fail_seen), .fail_exp(b_fail_exp), .match_count(b_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] d);
        exp_valid = 1'b1;
        exp_ch    = ch;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
        iobus_wr   = 1'b1;
        iobus_addr = addr;
        iobus_out  = d;
        tick();
        iobus_wr   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (a_exp_ready !== 1'b1) begin errors++; $display("FAIL reset_exp_ready: got %b want 1", a_exp_ready); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
        checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", a_pass); end
        checks++; if (a_fail_code !== 2'd0) begin errors++; $display("FAIL reset_fail_code: got %0d want 0", a_fail_code); end
        checks++; if (a_fail_ch !== 2'd0) begin errors++; $display("FAIL reset_fail_ch: got %0d want 0", a_fail_ch); end
        checks++; if (a_fail_seen !== 32'd0) begin errors++; $display("FAIL reset_fail_seen: got %h want 0", a_fail_seen); end
        checks++; if (a_fail_exp !== 32'd0) begin errors++; $display("FAIL reset_fail_exp: got %h want 0", a_fail_exp); end
        checks++; if (a_match !== 16'd0) begin errors++; $display("FAIL reset_match: got %0d want 0", a_match); end
    endtask

    task automatic test_fibonacci();
        logic [31:0] fib [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        pulse_clear();
        for (int i = 0; i < 10; i++) push(2'd0, fib[i]);
        pulse_start();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL fib_running: done got %b want 0", a_done); end
        for (int i = 0; i < 10; i++) bus_write(32'hFFFF0000, fib[i]);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL fib_done_latency: done got %b want 0 at last write edge", a_done); end
        tick();
        checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL fib_pass: got %b want 1", a_pass); end
        checks++; if (a_match !== 16'd10) begin errors++; $display("FAIL fib_match: got %0d want 10", a_match); end
    endtask

    task automatic test_mismatch();
        pulse_clear();
        push(2'd1, 32'd5);
        pulse_start();
        bus_write(32'hFFFF0004, 32'd6);
        checks++; if (a_fail_code !== 2'd1) begin errors++; $display("FAIL mm_code: got %0d want 1", a_fail_code); end
        checks++; if (a_fail_ch !== 2'd1) begin errors++; $display("FAIL mm_ch: got %0d want 1", a_fail_ch); end
        checks++; if (a_fail_seen !== 32'd6) begin errors++; $display("FAIL mm_seen: got %0d want 6", a_fail_seen); end
        checks++; if (a_fail_exp !== 32'd5) begin errors++; $display("FAIL mm_exp: got %0d want 5", a_fail_exp); end
        tick();
        checks++; if (a_done !== 1'b1 || a_pass !== 1'b0) begin errors++; $display("FAIL mm_state: done/pass got %b%b want 10", a_done, a_pass); end
    endtask

    task automatic test_overrun();
        pulse_clear();
        push(2'd0, 32'h11);
        push(2'd2, 32'h22);
        pulse_start();
        bus_write(32'hFFFF0000, 32'h11);
        bus_write(32'hFFFF0000, 32'd7);
        checks++; if (b_fail_code !== 2'd2) begin errors++; $display("FAIL ovr_code: got %0d want 2", b_fail_code); end
        checks++; if (b_fail_seen !== 32'd7) begin errors++; $display("FAIL ovr_seen: got %0d want 7", b_fail_seen); end
        checks++; if (b_fail_exp !== 32'd0 || b_fail_ch !== 2'd0) begin errors++; $display("FAIL ovr_exp_ch: got exp %0d ch %0d want 0 0", b_fail_exp, b_fail_ch); end
        tick();
        checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL ovr_keeps_running: done got %b want 0", b_done); end
        bus_write(32'hFFFF0008, 32'h22);
        tick();
        checks++; if (b_done !== 1'b1 || b_pass !== 1'b0) begin errors++; $display("FAIL ovr_final: done/pass got %b%b want 10", b_done, b_pass); end
        checks++; if (b_fail_code !== 2'd2) begin errors++; $display("FAIL ovr_final_code: got %0d want 2", b_fail_code); end
        checks++; if (b_match !== 16'd2) begin errors++; $display("FAIL ovr_match: got %0d want 2", b_match); end
        checks++; if (a_done !== 1'b1 || a_fail_code !== 2'd2) begin errors++; $display("FAIL ovr_stop_inst: done %b code %0d want 1 2", a_done, a_fail_code); end
    endtask

    task automatic test_timeout();
        pulse_clear();
        push(2'd0, 32'd1);
        pulse_start();
        repeat (49) tick();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL to_early: done got %b want 0 at cycle 49", a_done); end
        tick();
        checks++; if (a_done !== 1'b1 || a_fail_code !== 2'd3) begin errors++; $display("FAIL to_at_50: done %b code %0d want 1 3", a_done, a_fail_code); end

        pulse_clear();
        push(2'd0, 32'd1);
        push(2'd0, 32'd2);
        pulse_start();
        repeat (48) tick();
        bus_write(32'hFFFF0000, 32'd1);
        tick();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL to_restart_50: done got %b want 0", a_done); end
        repeat (48) tick();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL to_restart_98: done got %b want 0", a_done); end
        tick();
        checks++; if (a_done !== 1'b1 || a_fail_code !== 2'd3) begin errors++; $display("FAIL to_restart_99: done %b code %0d want 1 3", a_done, a_fail_code); end
        checks++; if (a_match !== 16'd1) begin errors++; $display("FAIL to_match: got %0d want 1", a_match); end
    endtask

    task automatic test_interleaved();
        pulse_clear();
        push(2'd0, 32'hA000_000A);
        push(2'd0, 32'hB000_000B);
        push(2'd3, 32'hC000_000C);
        pulse_start();
        bus_write(32'hFFFF000C, 32'hC000_000C);
        bus_write(32'hFFFF0100, 32'h1234_5678);
        checks++; if (a_fail_code !== 2'd0 || a_match !== 16'd1) begin errors++; $display("FAIL il_ignore: code %0d match %0d want 0 1", a_fail_code, a_match); end
        bus_write(32'hFFFF0000, 32'hA000_000A);
        bus_write(32'hFFFF0100, 32'hDEAD_BEEF);
        bus_write(32'hFFFF0000, 32'hB000_000B);
        tick();
        checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL il_pass: got %b want 1", a_pass); end
        checks++; if (a_match !== 16'd3) begin errors++; $display("FAIL il_match: got %0d want 3", a_match); end
    endtask

    task automatic test_clear_mid_run();
        pulse_clear();
        push(2'd0, 32'd10);
        push(2'd0, 32'd20);
        push(2'd0, 32'd30);
        pulse_start();
        checks++; if (a_exp_ready !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL clr_run: ready %b done %b want 0 0", a_exp_ready, a_done); end
        bus_write(32'hFFFF0000, 32'd10);
        checks++; if (a_match !== 16'd1) begin errors++; $display("FAIL clr_pre_match: got %0d want 1", a_match); end
        pulse_clear();
        checks++; if (a_exp_ready !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL clr_idle: ready %b done %b want 1 0", a_exp_ready, a_done); end
        checks++; if (a_match !== 16'd0) begin errors++; $display("FAIL clr_match: got %0d want 0", a_match); end
        pulse_start();
        checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL clr_empty_start: pass got %b want 1", a_pass); end
        // clear and start together: clear wins
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        checks++; if (a_done !== 1'b0 || a_exp_ready !== 1'b1) begin errors++; $display("FAIL clr_prio: done %b ready %b want 0 1", a_done, a_exp_ready); end
    endtask

    task automatic test_full();
        pulse_clear();
        for (int i = 0; i < 16; i++) push(2'd1, 32'(i));
        exp_ch = 2'd1;
        #1;
        checks++; if (a_exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", a_exp_ready); end
        exp_ch = 2'd2;
        #1;
        checks++; if (a_exp_ready !== 1'b1) begin errors++; $display("FAIL other_ready: got %b want 1", a_exp_ready); end
    endtask

    task automatic test_push_with_start();
        pulse_clear();
        exp_valid = 1'b1;
        exp_ch    = 2'd2;
        exp_data  = 32'd9;
        start     = 1'b1;
        tick();
        exp_valid = 1'b0;
        start     = 1'b0;
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL ps_run: done got %b want 0", a_done); end
        bus_write(32'hFFFF0008, 32'd9);
        tick();
        checks++; if (a_pass !== 1'b1 || a_match !== 16'd1) begin errors++; $display("FAIL ps_pass: pass %b match %0d want 1 1", a_pass, a_match); end
    endtask

    task automatic test_reset_mid_run();
        pulse_clear();
        push(2'd0, 32'd1);
        push(2'd0, 32'd2);
        pulse_start();
        bus_write(32'hFFFF0000, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (a_match !== 16'd0 || a_exp_ready !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL rst_mid: match %0d ready %b done %b want 0 1 0", a_match, a_exp_ready, a_done); end
        pulse_start();
        checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL rst_flushed: pass got %b want 1", a_pass); end
    endtask

    initial begin
        rst        = 1'b1;
        iobus_out  = '0;
        iobus_addr = '0;
        iobus_wr   = 1'b0;
        exp_valid  = 1'b0;
        exp_ch     = '0;
        exp_data   = '0;
        start      = 1'b0;
        clear      = 1'b0;

        test_reset();
        test_fibonacci();
        test_mismatch();
        test_overrun();
        test_timeout();
        test_interleaved();
        test_clear_mid_run();
        test_full();
        test_push_with_start();
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
